// File: rtl/accum_mult_arb.sv
// accum_mult_arb: round-robin front end for a shared, pipelined modular
// multiplier. Requesters compete for a single issue register, a credit
// counter bounds the number of outstanding multiplications, and returning
// results are routed back to their requester by the tag carried in ctl.
module accum_mult_arb #(
    parameter int unsigned BITS         = 381,
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned CTL_BITS     = 8,
    parameter int unsigned MAX_INFLIGHT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    // requester side
    input  logic [N_REQ-1:0]      i_req_val,
    output logic [N_REQ-1:0]      o_req_rdy,
    input  logic [N_REQ*BITS-1:0] i_req_dat_a,
    input  logic [N_REQ*BITS-1:0] i_req_dat_b,

    // multiplier issue side
    output logic                  o_mul_val,
    input  logic                  i_mul_rdy,
    output logic [2*BITS-1:0]     o_mul_dat,
    output logic [CTL_BITS-1:0]   o_mul_ctl,

    // multiplier result side
    input  logic                  i_res_val,
    output logic                  o_res_rdy,
    input  logic [BITS-1:0]       i_res_dat,
    input  logic [CTL_BITS-1:0]   i_res_ctl,

    // per-requester response side
    output logic [N_REQ-1:0]      o_rsp_val,
    input  logic [N_REQ-1:0]      i_rsp_rdy,
    output logic [BITS-1:0]       o_rsp_dat,

    // status
    output logic [7:0]            o_inflight,
    output logic                  o_err
);

    localparam int unsigned      IDX_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned      TAG_SPAN     = 32'd1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_REQ - 1);
    localparam logic [8:0]       CREDIT_LIMIT = 9'(MAX_INFLIGHT);

    // issue stage
    logic                  stage_val_q, stage_val_d;
    logic [BITS-1:0]       stage_a_q,   stage_a_d;
    logic [BITS-1:0]       stage_b_q,   stage_b_d;
    logic [IDX_W-1:0]      stage_tag_q, stage_tag_d;

    // arbitration pointer, credit counter, sticky error
    logic [IDX_W-1:0]      ptr_q,      ptr_d;
    logic [7:0]            inflight_q, inflight_d;
    logic                  err_q,      err_d;

    // combinational helpers
    logic                  stage_free;
    logic                  credit_ok;
    logic                  grant_en;
    logic                  gnt_found;
    logic [IDX_W-1:0]      gnt_idx;
    logic [N_REQ-1:0]      gnt_oh;
    logic                  grant;
    logic [BITS-1:0]       sel_a;
    logic [BITS-1:0]       sel_b;
    logic [IDX_W-1:0]      res_idx;
    logic [TAG_SPAN-1:0]   tag_in_range;
    logic                  res_upper_zero;
    logic                  res_tag_ok;
    logic                  issue;
    logic                  retire;

    // Grant eligibility: stage can take a new op and the op it will hold
    // still fits under the credit limit together with everything in flight.
    always_comb begin
        stage_free = !stage_val_q || i_mul_rdy;
        credit_ok  = ({1'b0, inflight_q} + {8'd0, stage_val_q}) < CREDIT_LIMIT;
        grant_en   = i_rst_n && stage_free && credit_ok;
    end

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!gnt_found && i_req_val[cand[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // One-hot accept and operand selection for the granted requester.
    always_comb begin
        gnt_oh = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (grant_en && gnt_found && (gnt_idx == IDX_W'(k))) begin
                gnt_oh[k] = 1'b1;
                sel_a     = i_req_dat_a[k*BITS +: BITS];
                sel_b     = i_req_dat_b[k*BITS +: BITS];
            end
        end
        grant = |gnt_oh;
    end

    // Issue stage and pointer next state: the stage only changes when it
    // is free, so a stalled operation stays put on the multiplier port.
    always_comb begin
        stage_val_d = stage_val_q;
        stage_a_d   = stage_a_q;
        stage_b_d   = stage_b_q;
        stage_tag_d = stage_tag_q;
        ptr_d       = ptr_q;
        if (stage_free) begin
            stage_val_d = grant;
        end
        if (grant) begin
            stage_a_d   = sel_a;
            stage_b_d   = sel_b;
            stage_tag_d = gnt_idx;
            ptr_d       = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Result routing by returned tag; an illegal tag is swallowed so the
    // multiplier can never be blocked by a result nobody can accept.
    always_comb begin
        res_idx = i_res_ctl[IDX_W-1:0];
        for (int unsigned k = 0; k < TAG_SPAN; k++) begin
            tag_in_range[k] = (k < N_REQ);
        end
        res_upper_zero = ((i_res_ctl >> IDX_W) == '0);
        res_tag_ok     = res_upper_zero && tag_in_range[res_idx];
        o_rsp_val      = '0;
        o_res_rdy      = 1'b0;
        if (i_rst_n) begin
            if (res_tag_ok) begin
                o_res_rdy          = i_rsp_rdy[res_idx];
                o_rsp_val[res_idx] = i_res_val;
            end else begin
                o_res_rdy = 1'b1;
            end
        end
        o_rsp_dat = i_res_dat;
    end

    // Credit accounting: issue adds, retire subtracts, both together cancel;
    // a retire with nothing outstanding is flagged and the count holds at 0.
    always_comb begin
        issue      = stage_val_q && i_mul_rdy;
        retire     = i_res_val && o_res_rdy;
        inflight_d = inflight_q;
        err_d      = err_q;
        if (retire && !res_tag_ok) begin
            err_d = 1'b1;
        end
        if (issue && !retire) begin
            inflight_d = inflight_q + 8'd1;
        end else if (retire && !issue) begin
            if (inflight_q == '0) begin
                err_d = 1'b1;
            end else begin
                inflight_d = inflight_q - 8'd1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage_val_q <= 1'b0;
            stage_a_q   <= '0;
            stage_b_q   <= '0;
            stage_tag_q <= '0;
            ptr_q       <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            stage_val_q <= stage_val_d;
            stage_a_q   <= stage_a_d;
            stage_b_q   <= stage_b_d;
            stage_tag_q <= stage_tag_d;
            ptr_q       <= ptr_d;
            inflight_q  <= inflight_d;
            err_q       <= err_d;
        end
    end

    assign o_req_rdy  = gnt_oh;
    assign o_mul_val  = stage_val_q;
    assign o_mul_dat  = {stage_b_q, stage_a_q};
    assign o_mul_ctl  = CTL_BITS'(stage_tag_q);
    assign o_inflight = inflight_q;
    assign o_err      = err_q;

endmodule
